sha256_block_feeder: RTL

Upstream stage of the sha256 compression core. Accepts a byte message of up to MAX_BYTES bytes (default 80, a block header), applies SHA-256 padding, and splits the result into 512-bit blocks. Sequences each block into the core with the correct chaining value and returns the final 256-bit digest with a one-cycle valid strobe.

---
 rtl/sha256_block_feeder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder: pads a short byte message into 512-bit blocks and
// sequences them through the sha256 compression core, returning the digest.
module sha256_block_feeder #(
  parameter int MAX_BYTES = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*MAX_BYTES-1:0] msg,
  input  logic [7:0]             msg_len,
  output logic                   busy,
  output logic                   err,
  output logic [255:0]           digest,
  output logic                   digest_valid,
  output logic                   core_enable,
  output logic [511:0]           core_data,
  output logic [255:0]           core_hash_in,
  input  logic [255:0]           core_hash_out,
  input  logic                   core_done
);

  localparam int NBLK_MAX = (MAX_BYTES + 8) / 64 + 1;
  localparam int MW = 8 * MAX_BYTES;
  localparam int XW = 512 * NBLK_MAX;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [MW-1:0]   msg_q;
  logic [7:0]      len_q;
  logic [2:0]      blk;
  logic [255:0]    chain;
  logic            done_q;

  logic [2:0]      last_blk;
  logic            done_rise;
  logic [XW-1:0]   body;
  logic [XW-1:0]   shifted;
  logic [511:0]    pad;

  // Index of the final block: (len+8)/64 with len in bytes.
  assign last_blk  = 3'(({1'b0, len_q} + 9'd8) >> 6);
  assign done_rise = core_done & ~done_q;

  // Padded block k: message bytes below len, 0x80 marker at len,
  // bit length in the last 8 bytes of the final block.
  always_comb begin
    body = ({msg_q, {(XW - MW){1'b0}}}
            & ~({XW{1'b1}} >> {len_q, 3'b000}))
         | ({8'h80, {(XW - 8){1'b0}}} >> {len_q, 3'b000});
    shifted = body << {blk, 9'd0};
    pad = 512'(shifted >> (XW - 512));
    if (blk == last_blk) begin
      pad[63:0] = {53'd0, len_q, 3'b000};
    end
  end

  // Control FSM with registered outputs; core_done is edge-detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      msg_q        <= '0;
      len_q        <= '0;
      blk          <= '0;
      chain        <= IV;
      done_q       <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      core_enable  <= 1'b0;
      core_data    <= '0;
      core_hash_in <= IV;
    end else begin
      done_q       <= core_done;
      err          <= 1'b0;
      digest_valid <= 1'b0;
      core_enable  <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            if (int'(msg_len) > MAX_BYTES) begin
              err <= 1'b1;
            end else begin
              msg_q <= msg;
              len_q <= msg_len;
              blk   <= '0;
              busy  <= 1'b1;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          core_data    <= pad;
          core_hash_in <= (blk == 3'd0) ? IV : chain;
          core_enable  <= 1'b1;
          state        <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            chain <= core_hash_out;
            if (blk == last_blk) begin
              state <= DONE;
            end else begin
              blk   <= blk + 3'd1;
              state <= LOAD;
            end
          end
        end
        DONE: begin
          digest       <= chain;
          digest_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
